// File: rtl/countdown_bcd.sv
// rtl/countdown_bcd.sv - MM:SS packed-BCD cook-time countdown with done/load_err pulses
// Optional internal 1-in-TICK_DIV prescaler: define COUNTDOWN_INT_TICK_EN.
module countdown_bcd #(
`ifdef COUNTDOWN_INT_TICK_EN
    parameter int         TICK_DIV = 100,
`endif
    parameter logic [7:0] MAX_MIN  = 8'h99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       load,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       load_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic       r_running;
    logic       r_paused;
    logic       r_done;
    logic       r_load_err;

    logic [1:0] w_state_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic [7:0] w_dec_min;
    logic [7:0] w_dec_sec;
    logic       w_load_ok;
    logic       w_load_zero;
    logic       w_time_zero;
    logic       w_tick;

`ifdef COUNTDOWN_INT_TICK_EN
    // Prescaler only counts while in RUN, so every resume restarts a full second.
    logic [6:0] r_div;
    logic       w_unused_tick_in;

    assign w_unused_tick_in = tick_in;
    assign w_tick = (r_state == S_RUN) && (r_div == 7'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_RUN) || w_tick) begin
            r_div <= 7'd0;
        end else begin
            r_div <= r_div + 7'd1;
        end
    end
`else
    assign w_tick = tick_in;
`endif

    assign w_load_ok = (min_bcd[7:4] <= 4'd9) && (min_bcd[3:0] <= 4'd9) &&
                       (sec_bcd[7:4] <= 4'd5) && (sec_bcd[3:0] <= 4'd9) &&
                       (min_bcd <= MAX_MIN);
    assign w_load_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
    assign w_time_zero = (r_min == 8'h00) && (r_sec == 8'h00);

    // One-second BCD decrement with borrow from seconds into minutes.
    always_comb begin
        w_dec_min = r_min;
        w_dec_sec = r_sec;
        if (r_sec[3:0] != 4'd0) begin
            w_dec_sec[3:0] = r_sec[3:0] - 4'd1;
        end else if (r_sec[7:4] != 4'd0) begin
            w_dec_sec = {r_sec[7:4] - 4'd1, 4'd9};
        end else begin
            w_dec_sec = 8'h59;
            if (r_min[3:0] != 4'd0) begin
                w_dec_min[3:0] = r_min[3:0] - 4'd1;
            end else begin
                w_dec_min = {r_min[7:4] - 4'd1, 4'd9};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_min_nxt   = 8'h00;
            w_sec_nxt   = 8'h00;
        end else if (load) begin
            if (r_state != S_RUN) begin
                if (w_load_ok) begin
                    w_min_nxt   = min_bcd;
                    w_sec_nxt   = sec_bcd;
                    w_state_nxt = w_load_zero ? S_IDLE : S_READY;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
        end else if (start) begin
            if (((r_state == S_READY) || (r_state == S_PAUSE)) && !w_time_zero) begin
                w_state_nxt = S_RUN;
            end
        end else if (pause) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else if (w_tick && (r_state == S_RUN)) begin
            w_min_nxt = w_dec_min;
            w_sec_nxt = w_dec_sec;
            if ((w_dec_min == 8'h00) && (w_dec_sec == 8'h00)) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_running  <= 1'b0;
            r_paused   <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_running  <= (w_state_nxt == S_RUN);
            r_paused   <= (w_state_nxt == S_PAUSE);
            r_done     <= w_done_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    assign min_out  = r_min;
    assign sec_out  = r_sec;
    assign running  = r_running;
    assign paused   = r_paused;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_bcd.sv
// tb/tb_countdown_bcd.sv - scoreboard bench for countdown_bcd (directed vectors)
module tb_countdown_bcd;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b0;
    logic       load = 1'b0;
    logic [7:0] min_bcd = 8'h00;
    logic [7:0] sec_bcd = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       paused;
    logic       done;
    logic       load_err;

    countdown_bcd dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .load(load),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .start(start), .pause(pause),
        .clear(clear), .min_out(min_out), .sec_out(sec_out), .running(running),
        .paused(paused), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // cmd bits: {rst, clear, load, start, pause, tick}
    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] R  = 6'b100000;
    localparam logic [5:0] CL = 6'b010000;
    localparam logic [5:0] LD = 6'b001000;
    localparam logic [5:0] ST = 6'b000100;
    localparam logic [5:0] PA = 6'b000010;
    localparam logic [5:0] TK = 6'b000001;
    // flag bits: {running, paused, done, load_err}
    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_RUN  = 4'b1000;
    localparam logic [3:0] F_PAU  = 4'b0100;
    localparam logic [3:0] F_DONE = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0001;
    localparam logic [3:0] F_PERR = 4'b0101;

    typedef struct {
        logic [7:0] mn;
        logic [7:0] sc;
        logic [3:0] fl;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic step(input logic [5:0] c, input logic [7:0] mi, input logic [7:0] se,
                        input logic [7:0] emin, input logic [7:0] esec,
                        input logic [3:0] efl, input string nm);
        exp_t e;
        @(negedge clk);
        {rst, clear, load, start, pause, tick_in} = c;
        min_bcd = mi;
        sec_bcd = se;
        e.mn = emin;
        e.sc = esec;
        e.fl = efl;
        e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: each queued entry is the state expected just after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({min_out, sec_out, running, paused, done, load_err} !== {e.mn, e.sc, e.fl}) begin
                    errors++;
                    $display("FAIL %s: got %h:%h run=%b pau=%b done=%b err=%b, exp %h:%h flags=%b",
                             e.nm, min_out, sec_out, running, paused, done, load_err, e.mn, e.sc, e.fl);
                end
            end
        end
    end

    initial begin
        step(R,  8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "reset0");
        step(R,  8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "reset1");
        step(NO, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "idle_after_reset");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "start_in_idle_ignored");
`ifdef COUNTDOWN_INT_TICK_EN
        step(LD, 8'h00, 8'h02, 8'h00, 8'h02, F_IDLE, "int_load_0002");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h02, F_RUN,  "int_start");
        for (int i = 1; i < 100; i++) step(NO, 8'h00, 8'h00, 8'h00, 8'h02, F_RUN, "int_hold_02");
        step(NO, 8'h00, 8'h00, 8'h00, 8'h01, F_RUN,  "int_tick_100");
        for (int i = 1; i < 100; i++) step(NO, 8'h00, 8'h00, 8'h00, 8'h01, F_RUN, "int_hold_01");
        step(NO, 8'h00, 8'h00, 8'h00, 8'h00, F_DONE, "int_done_200");
        step(NO, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "int_after_done");
`else
        // 01:00 countdown to done
        step(LD, 8'h01, 8'h00, 8'h01, 8'h00, F_IDLE, "load_0100");
        step(TK, 8'h00, 8'h00, 8'h01, 8'h00, F_IDLE, "tick_in_ready_ignored");
        step(ST, 8'h00, 8'h00, 8'h01, 8'h00, F_RUN,  "start_0100");
        for (int s = 59; s >= 1; s--) step(TK, 8'h00, 8'h00, 8'h00, to_bcd(s), F_RUN, "count_0100");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h00, F_DONE, "done_0100");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "done_single_pulse");
        // minutes borrow and load rejection
        step(LD, 8'h10, 8'h00, 8'h10, 8'h00, F_IDLE, "load_1000");
        step(ST, 8'h00, 8'h00, 8'h10, 8'h00, F_RUN,  "start_1000");
        step(TK, 8'h00, 8'h00, 8'h09, 8'h59, F_RUN,  "borrow_0959");
        step(LD, 8'h03, 8'h00, 8'h09, 8'h59, F_RUN,  "load_in_run_ignored");
        step(PA | TK, 8'h00, 8'h00, 8'h09, 8'h59, F_PAU, "pause_beats_tick");
        step(LD, 8'h09, 8'h60, 8'h09, 8'h59, F_PERR, "bad_sec60_paused");
        step(NO, 8'h00, 8'h00, 8'h09, 8'h59, F_PAU,  "err_single_pulse");
        step(CL, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "clear_paused");
        step(LD, 8'h00, 8'h60, 8'h00, 8'h00, F_ERR,  "bad_sec60_idle");
        step(LD, 8'h1A, 8'h00, 8'h00, 8'h00, F_ERR,  "bad_min_units");
        step(LD, 8'h99, 8'h59, 8'h99, 8'h59, F_IDLE, "load_max_9959");
        step(LD | ST, 8'h02, 8'h00, 8'h02, 8'h00, F_IDLE, "load_beats_start");
        step(LD, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "load_zero_idle");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "start_zero_ignored");
        // pause/resume 00:05
        step(LD, 8'h00, 8'h05, 8'h00, 8'h05, F_IDLE, "load_0005");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h05, F_RUN,  "start_0005");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h04, F_RUN,  "tick_0004");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h03, F_RUN,  "tick_0003");
        step(PA, 8'h00, 8'h00, 8'h00, 8'h03, F_PAU,  "pause_0003");
        for (int i = 0; i < 3; i++) step(TK, 8'h00, 8'h00, 8'h00, 8'h03, F_PAU, "paused_hold");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h03, F_RUN,  "resume_0003");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h02, F_RUN,  "tick_0002");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h01, F_RUN,  "tick_0001");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h00, F_DONE, "done_0005");
        step(NO, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "after_done_0005");
        // clear beats tick at 00:01; reset mid-run
        step(LD, 8'h00, 8'h02, 8'h00, 8'h02, F_IDLE, "load_0002");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h02, F_RUN,  "start_0002");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h01, F_RUN,  "tick_0001b");
        step(CL | TK, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "clear_beats_tick");
        step(NO, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "no_done_after_clear");
        step(LD, 8'h00, 8'h30, 8'h00, 8'h30, F_IDLE, "load_0030");
        step(ST, 8'h00, 8'h00, 8'h00, 8'h30, F_RUN,  "start_0030");
        step(R | TK, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "reset_mid_run");
        step(TK, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "tick_after_reset");
`endif
        step(NO, 8'h00, 8'h00, 8'h00, 8'h00, F_IDLE, "final_idle");
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
